// File: rtl/matmul_out_serializer.sv
// Result-tile serializer: captures all result vectors of a tile in one cycle and
// streams them one vector per beat over valid/ready, counting tiles and flagging drops.
module matmul_out_serializer #(
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 4,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 2,
    parameter int TOTAL_INPUT_W = 2,
    parameter int CNT_W         = 16,
    localparam int OUT_W = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES,
    localparam int IDX_W = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OUT_W-1:0] in_data [TOTAL_INPUT_W],
    output logic             in_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_last,
    output logic             overflow,
    output logic [CNT_W-1:0] tile_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_INPUT_W - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [OUT_W-1:0] cap_buf [TOTAL_INPUT_W];
    logic [IDX_W-1:0] idx;
    logic             at_last;
    logic             hs;

    // Output beat is a pure mux of the registered capture buffer.
    assign at_last  = (idx == LAST_IDX);
    assign m_valid  = (state == SEND);
    assign m_last   = m_valid & at_last;
    assign m_idx    = idx;
    assign m_data   = cap_buf[idx];
    assign hs       = m_valid & m_ready;
    assign in_ready = (state == IDLE) | (hs & at_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            overflow <= 1'b0;
            tile_cnt <= '0;
            for (int i = 0; i < TOTAL_INPUT_W; i++) begin
                cap_buf[i] <= '0;
            end
        end else begin
            // A tile offered while busy is dropped; only the sticky flag records it.
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_buf <= in_data;
                        idx     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (!at_last) begin
                            idx <= idx + IDX_W'(1);
                        end else begin
                            tile_cnt <= tile_cnt + CNT_W'(1);
                            idx      <= '0;
                            if (in_valid) begin
                                cap_buf <= in_data;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_out_serializer.sv
// Directed bench for matmul_out_serializer: a scoreboard queue holds expected beats,
// popped by a monitor on each handshake; control outputs checked at directed points.
module tb_matmul_out_serializer;

    localparam int OUT_W = 512;
    localparam int TIW   = 2;
    localparam int IDX_W = 1;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic [IDX_W-1:0] i;
        logic             l;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [OUT_W-1:0] in_data [TIW];
    logic             in_ready;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic [IDX_W-1:0] m_idx;
    logic             m_last;
    logic             overflow;
    logic [CNT_W-1:0] tile_cnt;

    beat_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    n_fail  = 0;

    logic [OUT_W-1:0] d_a5, d_5a, d_11, d_22, d_33, d_44, d_66, d_77;

    matmul_out_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_idx    (m_idx),
        .m_last   (m_last),
        .overflow (overflow),
        .tile_cnt (tile_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [OUT_W-1:0] d0, input logic [OUT_W-1:0] d1, input bit accepted);
        in_data[0] = d0;
        in_data[1] = d1;
        in_valid   = 1'b1;
        if (accepted) begin
            sb.push_back('{d: d0, i: 1'b0, l: 1'b0});
            sb.push_back('{d: d1, i: 1'b1, l: 1'b1});
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        m_ready  = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || m_valid); i++) begin
            cyc();
        end
        chk(tag, OUT_W'(sb.size() == 0 && !m_valid), OUT_W'(1));
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", OUT_W'(m_idx), OUT_W'(2));
            end else begin
                e = sb.pop_front();
                chk("beat_data", m_data, e.d);
                chk("beat_idx", OUT_W'(m_idx), OUT_W'(e.i));
                chk("beat_last", OUT_W'(m_last), OUT_W'(e.l));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        d_a5 = {64{8'hA5}};
        d_5a = {64{8'h5A}};
        d_11 = {64{8'h11}};
        d_22 = {64{8'h22}};
        d_33 = {64{8'h33}};
        d_44 = {64{8'h44}};
        d_66 = {64{8'h66}};
        d_77 = {64{8'h77}};
        in_data[0] = '0;
        in_data[1] = '0;

        // 1: reset and idle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc();
            @(negedge clk);
            chk("idle_m_valid", OUT_W'(m_valid), OUT_W'(0));
            chk("idle_in_ready", OUT_W'(in_ready), OUT_W'(1));
        end
        chk("rst_tile_cnt", OUT_W'(tile_cnt), OUT_W'(0));
        chk("rst_overflow", OUT_W'(overflow), OUT_W'(0));
        chk("rst_m_data", m_data, '0);
        chk("rst_m_last", OUT_W'(m_last), OUT_W'(0));

        // 2: single tile, consumer always ready
        cyc();
        m_ready = 1'b1;
        offer(d_a5, d_5a, 1'b1);
        @(negedge clk);
        chk("t2_in_ready", OUT_W'(in_ready), OUT_W'(1));
        chk("t2_valid_before", OUT_W'(m_valid), OUT_W'(0));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid_lat1", OUT_W'(m_valid), OUT_W'(1));
        wait_drain("t2_drain");
        chk("t2_tile_cnt", OUT_W'(tile_cnt), OUT_W'(1));

        // 3: backpressure on beat0
        do_reset();
        cyc();
        offer(d_a5, d_5a, 1'b1);
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", OUT_W'(m_valid), OUT_W'(1));
            chk("t3_hold_data", m_data, d_a5);
            chk("t3_hold_idx", OUT_W'(m_idx), OUT_W'(0));
            chk("t3_hold_last", OUT_W'(m_last), OUT_W'(0));
            cyc();
        end
        wait_drain("t3_drain");
        chk("t3_tile_cnt", OUT_W'(tile_cnt), OUT_W'(1));

        // 4: back-to-back tile on last-beat handshake
        do_reset();
        m_ready = 1'b1;
        cyc();
        offer(d_a5, d_5a, 1'b1);
        cyc();
        in_valid = 1'b0;
        cyc();
        offer(d_11, d_22, 1'b1);
        @(negedge clk);
        chk("t4_last_beat", OUT_W'(m_last), OUT_W'(1));
        chk("t4_in_ready", OUT_W'(in_ready), OUT_W'(1));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_no_gap_valid", OUT_W'(m_valid), OUT_W'(1));
        chk("t4_no_gap_data", m_data, d_11);
        chk("t4_no_gap_idx", OUT_W'(m_idx), OUT_W'(0));
        wait_drain("t4_drain");
        chk("t4_tile_cnt", OUT_W'(tile_cnt), OUT_W'(2));
        chk("t4_overflow", OUT_W'(overflow), OUT_W'(0));

        // 5: overflow while busy
        do_reset();
        cyc();
        offer(d_a5, d_5a, 1'b1);
        cyc();
        offer(d_33, d_44, 1'b0);
        @(negedge clk);
        chk("t5_in_ready_busy", OUT_W'(in_ready), OUT_W'(0));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_overflow_set", OUT_W'(overflow), OUT_W'(1));
        chk("t5_data_kept", m_data, d_a5);
        chk("t5_idx_kept", OUT_W'(m_idx), OUT_W'(0));
        wait_drain("t5_drain");
        chk("t5_tile_cnt", OUT_W'(tile_cnt), OUT_W'(1));
        for (int k = 0; k < 4; k++) cyc();
        chk("t5_overflow_sticky", OUT_W'(overflow), OUT_W'(1));

        // 6: reset mid-stream aborts the tile
        do_reset();
        chk("t6_overflow_cleared", OUT_W'(overflow), OUT_W'(0));
        cyc();
        offer(d_a5, d_5a, 1'b1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid_before_rst", OUT_W'(m_valid), OUT_W'(1));
        cyc();
        rst = 1'b1;
        sb.delete();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid_after_rst", OUT_W'(m_valid), OUT_W'(0));
        chk("t6_tile_cnt", OUT_W'(tile_cnt), OUT_W'(0));
        chk("t6_overflow", OUT_W'(overflow), OUT_W'(0));
        chk("t6_in_ready", OUT_W'(in_ready), OUT_W'(1));
        cyc();
        m_ready = 1'b1;
        offer(d_66, d_77, 1'b1);
        cyc();
        in_valid = 1'b0;
        wait_drain("t6_drain");
        chk("t6_tile_cnt_after", OUT_W'(tile_cnt), OUT_W'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
